// File: rtl/phys_reg_release_queue_pkg.sv
// Shared superscalar types for the physical-register release queue.
// Consumed by phys_reg_release_queue (optional flush FSM under RELEASE_QUEUE_FLUSH_EN).
package phys_reg_release_queue_pkg;
   localparam int PRQ_DEPTH       = 32;
   localparam int PRQ_TAG_W       = 5;
   localparam int PHYS_ADDR_WIDTH = 6;

   typedef struct packed {
      logic                       valid;
      logic                       done;
      logic                       has_rd;
      logic [PHYS_ADDR_WIDTH-1:0] new_phys;
      logic [PHYS_ADDR_WIDTH-1:0] old_phys;
   } prq_entry_t;

   typedef enum logic {RUN, FLUSH} prq_state_e;
endpackage

// File: rtl/phys_reg_release_queue_if.sv
// Rename-side alloc, writeback completion and RAT commit/free bundle of the release queue.
interface phys_reg_release_queue_if
   import phys_reg_release_queue_pkg::*;
#(parameter int TAG_W = PRQ_TAG_W);
   logic [2:0]                 alloc_valid;
   logic [2:0]                 alloc_has_rd;
   logic [PHYS_ADDR_WIDTH-1:0] alloc_new_phys_0, alloc_new_phys_1, alloc_new_phys_2;
   logic [PHYS_ADDR_WIDTH-1:0] alloc_old_phys_0, alloc_old_phys_1, alloc_old_phys_2;
   logic                       alloc_ready;
   logic [TAG_W-1:0]           alloc_tag_0, alloc_tag_1, alloc_tag_2;
   logic [2:0]                 cmpl_valid;
   logic [TAG_W-1:0]           cmpl_tag_0, cmpl_tag_1, cmpl_tag_2;
   logic [2:0]                 commit_valid;
   logic [PHYS_ADDR_WIDTH-1:0] free_phys_reg_0, free_phys_reg_1, free_phys_reg_2;
   logic [1:0]                 retire_count;
   logic                       queue_empty;
   logic [TAG_W:0]             queue_count;

   modport master (
      output alloc_valid, alloc_has_rd, alloc_new_phys_0, alloc_new_phys_1, alloc_new_phys_2,
             alloc_old_phys_0, alloc_old_phys_1, alloc_old_phys_2,
             cmpl_valid, cmpl_tag_0, cmpl_tag_1, cmpl_tag_2,
      input  alloc_ready, alloc_tag_0, alloc_tag_1, alloc_tag_2, commit_valid,
             free_phys_reg_0, free_phys_reg_1, free_phys_reg_2, retire_count,
             queue_empty, queue_count
   );

   modport slave (
      input  alloc_valid, alloc_has_rd, alloc_new_phys_0, alloc_new_phys_1, alloc_new_phys_2,
             alloc_old_phys_0, alloc_old_phys_1, alloc_old_phys_2,
             cmpl_valid, cmpl_tag_0, cmpl_tag_1, cmpl_tag_2,
      output alloc_ready, alloc_tag_0, alloc_tag_1, alloc_tag_2, commit_valid,
             free_phys_reg_0, free_phys_reg_1, free_phys_reg_2, retire_count,
             queue_empty, queue_count
   );
endinterface

// File: rtl/phys_reg_release_queue_lead_done_counter.sv
// Counts leading set bits (0-3) in a 3-entry window, capped at queue occupancy.
module prq_lead_done_counter #(
   parameter int CNT_W = 6
) (
   input  logic [2:0]       done,
   input  logic [CNT_W-1:0] count,
   output logic [1:0]       k
);
   always_comb begin
      k = 2'd0;
      if (done[0] && count >= CNT_W'(1)) begin
         k = 2'd1;
         if (done[1] && count >= CNT_W'(2)) begin
            k = 2'd2;
            if (done[2] && count >= CNT_W'(3)) k = 2'd3;
         end
      end
   end
endmodule

// File: rtl/phys_reg_release_queue.sv
// In-order release queue: retires up to 3 done entries/cycle and frees displaced phys regs.
// RELEASE_QUEUE_FLUSH_EN adds a flush input that unwinds youngest entries, freeing new_phys.
module phys_reg_release_queue
   import phys_reg_release_queue_pkg::*;
#(
   parameter int DEPTH = PRQ_DEPTH,
   parameter int TAG_W = $clog2(DEPTH)
) (
   input logic clk,
   input logic reset,
`ifdef RELEASE_QUEUE_FLUSH_EN
   input logic flush,
`endif
   phys_reg_release_queue_if.slave bus
);
   localparam int CW = TAG_W + 1;

   prq_entry_t                        ent [DEPTH];
   logic [CW-1:0]                     head, tail, count;
   logic [2:0][PHYS_ADDR_WIDTH-1:0]   a_new, a_old, free_q;
   logic [2:0][TAG_W-1:0]             c_tag, a_tag, h_idx, t_idx;
   logic [2:0][1:0]                   a_off;
   logic [1:0]                        n_alloc, k, rcnt_q;
   logic [2:0]                        lead_bits, commit_q;
   logic                              flushing, flush_req, alloc_ready_c;

   assign a_new = {bus.alloc_new_phys_2, bus.alloc_new_phys_1, bus.alloc_new_phys_0};
   assign a_old = {bus.alloc_old_phys_2, bus.alloc_old_phys_1, bus.alloc_old_phys_0};
   assign c_tag = {bus.cmpl_tag_2, bus.cmpl_tag_1, bus.cmpl_tag_0};

`ifdef RELEASE_QUEUE_FLUSH_EN
   prq_state_e state;
   assign flushing  = (state == FLUSH);
   assign flush_req = flush && (state == RUN);
`else
   assign flushing  = 1'b0;
   assign flush_req = 1'b0;
`endif

   // Extra MSB on head/tail keeps full and empty distinct after wrap.
   assign count         = tail - head;
   assign alloc_ready_c = !flushing && (((CW+1)'(DEPTH) - {1'b0, count}) >= (CW+1)'(3));

   always_comb begin
      a_off[0] = 2'd0;
      a_off[1] = {1'b0, bus.alloc_valid[0]};
      a_off[2] = {1'b0, bus.alloc_valid[0]} + {1'b0, bus.alloc_valid[1]};
      n_alloc  = a_off[2] + {1'b0, bus.alloc_valid[2]};
   end

   for (genvar i = 0; i < 3; i++) begin : g_lane
      assign a_tag[i]     = tail[TAG_W-1:0] + TAG_W'(a_off[i]);
      assign h_idx[i]     = head[TAG_W-1:0] + TAG_W'(i);
      assign t_idx[i]     = tail[TAG_W-1:0] - TAG_W'(i + 1);
      // While flushing every occupied entry is poppable, so count valids from the tail.
      assign lead_bits[i] = flushing ? ent[t_idx[i]].valid : ent[h_idx[i]].done;
   end

   prq_lead_done_counter #(.CNT_W(CW)) u_lead (
      .done  (lead_bits),
      .count (count),
      .k     (k)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
         head     <= '0;
         tail     <= '0;
         commit_q <= '0;
         free_q   <= '0;
         rcnt_q   <= '0;
`ifdef RELEASE_QUEUE_FLUSH_EN
         state    <= RUN;
`endif
      end else begin
         commit_q <= '0;
         free_q   <= '0;
         rcnt_q   <= '0;
         if (flushing) begin
            for (int j = 0; j < 3; j++) begin
               if (2'(j) < k) begin
                  commit_q[j]    <= ent[t_idx[j]].has_rd;
                  free_q[j]      <= ent[t_idx[j]].new_phys;
                  ent[t_idx[j]]  <= '0;
               end
            end
            tail   <= tail - CW'(k);
            rcnt_q <= k;
`ifdef RELEASE_QUEUE_FLUSH_EN
            if (count == CW'(k)) state <= RUN;
`endif
         end else if (flush_req) begin
`ifdef RELEASE_QUEUE_FLUSH_EN
            state <= FLUSH;
`endif
         end else begin
            for (int j = 0; j < 3; j++)
               if (bus.cmpl_valid[j] && ent[c_tag[j]].valid) ent[c_tag[j]].done <= 1'b1;
            // k comes from pre-edge done bits, so a same-edge completion at head waits a cycle.
            for (int j = 0; j < 3; j++) begin
               if (2'(j) < k) begin
                  commit_q[j]   <= ent[h_idx[j]].has_rd;
                  free_q[j]     <= ent[h_idx[j]].has_rd ? ent[h_idx[j]].old_phys : '0;
                  ent[h_idx[j]] <= '0;
               end
            end
            head   <= head + CW'(k);
            rcnt_q <= k;
            if (alloc_ready_c) begin
               for (int i = 0; i < 3; i++)
                  if (bus.alloc_valid[i])
                     ent[a_tag[i]] <= '{valid: 1'b1, done: 1'b0, has_rd: bus.alloc_has_rd[i],
                                        new_phys: a_new[i], old_phys: a_old[i]};
               tail <= tail + CW'(n_alloc);
            end
         end
      end
   end

   assign bus.alloc_ready     = alloc_ready_c;
   assign bus.alloc_tag_0     = a_tag[0];
   assign bus.alloc_tag_1     = a_tag[1];
   assign bus.alloc_tag_2     = a_tag[2];
   assign bus.commit_valid    = commit_q;
   assign bus.free_phys_reg_0 = free_q[0];
   assign bus.free_phys_reg_1 = free_q[1];
   assign bus.free_phys_reg_2 = free_q[2];
   assign bus.retire_count    = rcnt_q;
   assign bus.queue_empty     = (count == '0);
   assign bus.queue_count     = count;
endmodule

// File: tb/tb_phys_reg_release_queue.sv
// Scoreboard bench for phys_reg_release_queue; flush scenario built with RELEASE_QUEUE_FLUSH_EN.
module tb_phys_reg_release_queue;
   logic clk, reset, flush;
   int   n_cmp, n_err, cyc;

   typedef struct {
      logic [4:0] tag;
      logic       hr;
      logic [5:0] nw, od;
      logic       done;
   } ment_t;

   typedef struct {
      logic [2:0]      cv;
      logic [2:0][5:0] f;
      logic [1:0]      rc;
      int              cnt;
   } exp_t;

   ment_t mq[$];
   exp_t  exp_q[$];
   int    mtail;
   bit    mflush;

   phys_reg_release_queue_if #(.TAG_W(5)) bus ();

   phys_reg_release_queue dut (
      .clk   (clk),
      .reset (reset),
`ifdef RELEASE_QUEUE_FLUSH_EN
      .flush (flush),
`endif
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("commit_valid", bus.commit_valid, e.cv);
         chk("free0", bus.free_phys_reg_0, e.f[0]);
         chk("free1", bus.free_phys_reg_1, e.f[1]);
         chk("free2", bus.free_phys_reg_2, e.f[2]);
         chk("retire_count", bus.retire_count, e.rc);
         chk("queue_count", bus.queue_count, e.cnt);
         chk("queue_empty", bus.queue_empty, e.cnt == 0);
      end
   end

   function automatic bit model_ready();
      return !mflush && (32 - mq.size() >= 3);
   endfunction

   // One clock: drive inputs, check combinational outputs, push the expected post-edge result.
   task automatic cycle(input logic [2:0] av, input logic [2:0] hr, input logic [5:0] nb,
                        input logic [5:0] ob, input logic [2:0] cv, input logic [4:0] t0,
                        input logic [4:0] t1, input logic [4:0] t2, input logic fl);
      exp_t       e;
      ment_t      m;
      logic [4:0] ct[3];
      logic [4:0] tg;
      bit         rdy;
      int         off, k;
      ct = '{t0, t1, t2};
      bus.alloc_valid = av;  bus.alloc_has_rd = hr;
      bus.alloc_new_phys_0 = nb;      bus.alloc_old_phys_0 = ob;
      bus.alloc_new_phys_1 = nb + 1;  bus.alloc_old_phys_1 = ob + 1;
      bus.alloc_new_phys_2 = nb + 2;  bus.alloc_old_phys_2 = ob + 2;
      bus.cmpl_valid = cv;  bus.cmpl_tag_0 = t0;  bus.cmpl_tag_1 = t1;  bus.cmpl_tag_2 = t2;
      flush = fl;
      rdy = model_ready();
      #1;
      chk("alloc_ready", bus.alloc_ready, rdy);
      off = 0;
      for (int i = 0; i < 3; i++) begin
         if (av[i]) begin
            tg = 5'(mtail + off);
            if (i == 0) chk("alloc_tag0", bus.alloc_tag_0, tg);
            if (i == 1) chk("alloc_tag1", bus.alloc_tag_1, tg);
            if (i == 2) chk("alloc_tag2", bus.alloc_tag_2, tg);
            off++;
         end
      end
      e.cv = '0;  e.f = '0;  e.rc = '0;
      k = 0;
      if (mflush) begin
         while (k < 3 && mq.size() > 0) begin
            m = mq.pop_back();
            e.cv[k] = m.hr;  e.f[k] = m.nw;  k++;
         end
         mtail -= k;
         if (mq.size() == 0) mflush = 0;
      end else if (fl) begin
         mflush = 1;
      end else begin
         while (k < 3 && mq.size() > 0 && mq[0].done) begin
            m = mq.pop_front();
            e.cv[k] = m.hr;  e.f[k] = m.hr ? m.od : 6'd0;  k++;
         end
         for (int j = 0; j < 3; j++)
            if (cv[j]) foreach (mq[q]) if (mq[q].tag == ct[j]) mq[q].done = 1'b1;
         if (rdy) begin
            off = 0;
            for (int i = 0; i < 3; i++) begin
               if (av[i]) begin
                  mq.push_back('{tag: 5'(mtail + off), hr: hr[i], nw: nb + 6'(i),
                                 od: ob + 6'(i), done: 1'b0});
                  off++;
               end
            end
            mtail += off;
         end
      end
      e.rc = 2'(k);
      e.cnt = mq.size();
      exp_q.push_back(e);
      @(negedge clk);
      bus.alloc_valid = '0;  bus.cmpl_valid = '0;  flush = 1'b0;
   endtask

   task automatic alloc(input logic [2:0] av, input logic [2:0] hr, input logic [5:0] nb,
                        input logic [5:0] ob);
      cycle(av, hr, nb, ob, 3'b000, 5'd0, 5'd0, 5'd0, 1'b0);
   endtask

   task automatic cmpl(input logic [2:0] cv, input logic [4:0] t0, input logic [4:0] t1,
                       input logic [4:0] t2);
      cycle(3'b000, 3'b000, 6'd0, 6'd0, cv, t0, t1, t2, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(3'b000, 3'b000, 6'd0, 6'd0, 3'b000, 5'd0, 5'd0, 5'd0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      mq.delete();  exp_q.delete();  mtail = 0;  mflush = 0;
      @(negedge clk);
      chk("rst_commit_valid", bus.commit_valid, 3'b000);
      chk("rst_free0", bus.free_phys_reg_0, 6'd0);
      chk("rst_free1", bus.free_phys_reg_1, 6'd0);
      chk("rst_free2", bus.free_phys_reg_2, 6'd0);
      chk("rst_retire_count", bus.retire_count, 2'd0);
      chk("rst_queue_empty", bus.queue_empty, 1'b1);
      chk("rst_queue_count", bus.queue_count, 6'd0);
      chk("rst_alloc_ready", bus.alloc_ready, 1'b1);
      reset = 1'b1;
   endtask

   logic [4:0] tl[$];
   logic [2:0] dv;
   logic [4:0] dt[3];

   initial begin
      n_cmp = 0;  n_err = 0;  cyc = 0;  mtail = 0;  mflush = 0;
      reset = 1'b0;  flush = 1'b0;
      bus.alloc_valid = '0;  bus.alloc_has_rd = '0;  bus.cmpl_valid = '0;
      bus.alloc_new_phys_0 = '0;  bus.alloc_new_phys_1 = '0;  bus.alloc_new_phys_2 = '0;
      bus.alloc_old_phys_0 = '0;  bus.alloc_old_phys_1 = '0;  bus.alloc_old_phys_2 = '0;
      bus.cmpl_tag_0 = '0;  bus.cmpl_tag_1 = '0;  bus.cmpl_tag_2 = '0;
      do_reset();

      // three-wide enqueue, complete all, retire all with frees 1,2,3
      alloc(3'b111, 3'b111, 6'd10, 6'd1);
      cmpl(3'b111, 5'd0, 5'd1, 5'd2);
      idle(2);

      // reset with live entries, then compacted allocation of slots 0 and 2
      alloc(3'b111, 3'b111, 6'd10, 6'd1);
      do_reset();
      alloc(3'b101, 3'b101, 6'd20, 6'd5);
      cmpl(3'b001, 5'd1, 5'd0, 5'd0);
      idle(2);
      cmpl(3'b001, 5'd0, 5'd0, 5'd0);
      idle(2);

      // middle lane without a destination
      alloc(3'b111, 3'b101, 6'd30, 6'd8);
      cmpl(3'b111, 5'd2, 5'd3, 5'd4);
      idle(2);

      // younger done entries wait behind the head; alloc + completion in one edge
      alloc(3'b111, 3'b111, 6'd33, 6'd11);
      cmpl(3'b110, 5'd0, 5'd6, 5'd7);
      idle(2);
      cycle(3'b111, 3'b111, 6'd50, 6'd20, 3'b001, 5'd5, 5'd0, 5'd0, 1'b0);
      idle(2);
      cmpl(3'b111, 5'd8, 5'd9, 5'd10);
      idle(2);

      // fill to 30, free 3, then wrap tags 31,0,1 and drain everything
      do_reset();
      while (model_ready()) alloc(3'b111, 3'b111, 6'(mtail), 6'(mtail + 7));
      idle(1);
      cmpl(3'b111, 5'd0, 5'd1, 5'd2);
      idle(2);
      alloc(3'b001, 3'b001, 6'd60, 6'd37);
      alloc(3'b111, 3'b111, 6'd61, 6'd38);
      tl.delete();
      foreach (mq[i]) tl.push_back(mq[i].tag);
      for (int i = 0; i < tl.size(); i += 3) begin
         dv = '0;  dt = '{5'd0, 5'd0, 5'd0};
         for (int j = 0; j < 3; j++)
            if (i + j < tl.size()) begin dv[j] = 1'b1;  dt[j] = tl[i + j]; end
         cmpl(dv, dt[0], dt[1], dt[2]);
      end
      idle(3);

`ifdef RELEASE_QUEUE_FLUSH_EN
      // flush five entries: youngest first, new_phys freed
      do_reset();
      alloc(3'b111, 3'b111, 6'd40, 6'd1);
      alloc(3'b011, 3'b111, 6'd43, 6'd4);
      cycle(3'b000, 3'b000, 6'd0, 6'd0, 3'b000, 5'd0, 5'd0, 5'd0, 1'b1);
      cycle(3'b000, 3'b000, 6'd0, 6'd0, 3'b001, 5'd0, 5'd0, 5'd0, 1'b1);
      idle(3);
`endif

      idle(1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/phys_reg_release_queue.md
Name: phys_reg_release_queue

Overview:
- In-order release queue sitting between rename and the register alias table's commit/free interface.
- Records each renamed instruction's old and new physical destination, marks entries done on writeback, and retires up to 3 oldest done entries per cycle.
- Retirement drives commit_valid[2:0] / free_phys_reg_0..2 into the register alias table so that displaced physical registers return to its free list.

Parameters:
- DEPTH, 32, number of queue entries (power of 2, ≥4)
- TAG_W, 5, log2(DEPTH); entry tag width
- PHYS_ADDR_WIDTH, 6, physical register index width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- alloc_valid  in  3  per-slot enqueue request, slot 0 oldest
- alloc_has_rd  in  3  slot writes a non-x0 destination
- alloc_new_phys_0/1/2  in  PHYS_ADDR_WIDTH  newly allocated physical register per slot
- alloc_old_phys_0/1/2  in  PHYS_ADDR_WIDTH  displaced physical register per slot
- alloc_ready  out  1  queue can accept 3 entries this cycle
- alloc_tag_0/1/2  out  TAG_W  tag assigned to each slot
- cmpl_valid  in  3  writeback completion strobes
- cmpl_tag_0/1/2  in  TAG_W  tag of completing entry
- commit_valid  out  3  release lane j is valid
- free_phys_reg_0/1/2  out  PHYS_ADDR_WIDTH  physical register to free per lane
- retire_count  out  2  entries retired last edge (0-3)
- queue_empty  out  1  count == 0
- queue_count  out  TAG_W+1  occupied entries

Behaviour:
- Storage: circular array of {valid, done, has_rd, new_phys, old_phys}. head and tail are TAG_W+1 bits; the extra bit disambiguates full from empty across wrap.
- Reset: all entry valid/done bits cleared; head = tail = 0. Outputs: commit_valid = 0, free_phys_reg_* = 0, retire_count = 0, queue_empty = 1, queue_count = 0, alloc_ready = 1.
- alloc_ready is combinational: (DEPTH - count) ≥ 3.
- Enqueue happens on the edge where alloc_ready = 1. Valid slots are compacted in slot order: slot i takes tail + popcount(alloc_valid[i-1:0]). tail advances by popcount(alloc_valid).
- alloc_tag_i is combinational, and is meaningful only when alloc_valid[i] = 1.
- Any alloc_valid bit set while alloc_ready = 0 is dropped; the bench asserts this never happens.
- Completion: on an edge with cmpl_valid[j] = 1, the entry at cmpl_tag_j gets done = 1. Completion to an invalid entry is ignored. Duplicate completions are harmless.
- Retire, evaluated each edge from pre-edge state:
  - k = number of consecutive done entries starting at head, capped at 3 and at count.
  - Retired entries are cleared and head advances by k.
  - Registered outputs: commit_valid[j] = has_rd of the j-th retired entry; free_phys_reg_j = its old_phys, or 0 if not has_rd; lanes ≥ k are 0; retire_count = k.
- Latency: completion at edge N sets done; earliest retirement is at edge N+1, with commit outputs visible after N+1. An entry enqueued at edge N can be completed at edge N+1 at the earliest.
- Simultaneous enqueue, completion and retire in one edge are all legal: count' = count + n_alloc − k. A completion landing at head in the same edge does not retire that edge.
- Retirement is strictly in order: a not-done head entry blocks all younger done entries.
- Full: count reaches DEPTH only if the caller violates alloc_ready; alloc_ready = 0 whenever fewer than 3 entries are free.
- Reset mid-operation discards all entries with no frees emitted. The register alias table is reset concurrently.

Optional Feature:
- Macro: RELEASE_QUEUE_FLUSH_EN.
- With the macro: adds input flush (1 bit) and a 2-state FSM, RUN → FLUSH.
  - flush = 1 in RUN: that edge performs no retire, no enqueue and no completion; state becomes FLUSH.
  - In FLUSH, alloc_ready = 0 and completions are ignored. Each edge pops up to 3 youngest entries from tail, emitting commit_valid[j] = has_rd and free_phys_reg_j = new_phys.
  - FLUSH → RUN on the edge where count reaches 0. flush asserted while in FLUSH is ignored.
  - Register alias table map restore is not this block's job.
- Without the macro: no flush port; the FSM reduces to RUN only.

Decomposition:
- Shared superscalar package holds: prq_entry_t struct, PRQ_DEPTH, PRQ_TAG_W, PHYS_ADDR_WIDTH, and the prq_state_e enum (RUN, FLUSH).
- One sub-module, prq_lead_done_counter: combinational, takes 3 done bits from head and count, returns k (0-3). It is reused for tail-side counting in FLUSH.

Test Plan:
- After reset, enqueue slots 0..2 with old_phys = 1, 2, 3 and has_rd = 111 → tags 0, 1, 2; complete all 3 in one cycle → next edge commit_valid = 111, free_phys_reg = 1, 2, 3, retire_count = 3, queue_empty = 1.
- Enqueue with alloc_valid = 101 → tags 0 and 1 assigned to slots 0 and 2; queue_count = 2.
- Complete tag 1 only → no retire; then complete tag 0 → commit_valid = 11 (lanes 0 and 1), free_phys_reg_0 = old of tag 0.
- has_rd = 0 entry retires → commit_valid bit 0 for that lane, free_phys_reg = 0, retire_count still counts it.
- Fill to count = 30 → alloc_ready = 0. Retire 3 → alloc_ready = 1; wrap past index 31 → tags 31, 0, 1 correct.
- RELEASE_QUEUE_FLUSH_EN: 5 entries with new_phys = 40..44 → flush → two FLUSH cycles free {44, 43, 42} then {41, 40}; then RUN, queue_empty = 1.
